mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 43 ++++
 rtl/mem_access_unit.sv | 218 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and SRAM bus bundle for mem_access_unit
// Purpose: groups the per-port request channels, the shared response channel
//          and the single-port SRAM bus of mem_access_unit.
// Ports (slave = the unit's view):
//   req_valid/req_ready/req_we/req_signed/req_addr/req_width/req_wdata - packed per-port requests
//   resp_valid/resp_err/resp_data                                    - completion pulse and load data
//   mem_ce/mem_we/mem_addr_o/mem_sel_o/mem_data_o/mem_data_i         - SRAM bus
interface mem_access_unit_if #(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32
);
    localparam int BYTES = DATA_W / 8;

    logic [NUM_PORTS-1:0]        req_valid;
    logic [NUM_PORTS-1:0]        req_ready;
    logic [NUM_PORTS-1:0]        req_we;
    logic [NUM_PORTS-1:0]        req_signed;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS*4-1:0]      req_width;
    logic [NUM_PORTS*DATA_W-1:0] req_wdata;
    logic [NUM_PORTS-1:0]        resp_valid;
    logic                        resp_err;
    logic [DATA_W-1:0]           resp_data;
    logic                        mem_ce;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr_o;
    logic [BYTES-1:0]            mem_sel_o;
    logic [DATA_W-1:0]           mem_data_o;
    logic [DATA_W-1:0]           mem_data_i;

    modport slave (
        input  req_valid, req_we, req_signed, req_addr, req_width, req_wdata, mem_data_i,
        output req_ready, resp_valid, resp_err, resp_data,
        output mem_ce, mem_we, mem_addr_o, mem_sel_o, mem_data_o
    );

    modport master (
        output req_valid, req_we, req_signed, req_addr, req_width, req_wdata, mem_data_i,
        input  req_ready, resp_valid, resp_err, resp_data,
        input  mem_ce, mem_we, mem_addr_o, mem_sel_o, mem_data_o
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - round-robin multi-port byte/half/word access unit in front of one SRAM
// Purpose: arbitrates NUM_PORTS requesters, splits unaligned accesses into two SRAM beats,
//          steers bytes onto little-endian lanes and sign/zero-extends load results.
// Ports:
//   clk - single clock, rising edge
//   rst - asynchronous active-low reset
//   bus - mem_access_unit_if.slave (requests, responses, SRAM bus)
module mem_access_unit #(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_unit_if.slave bus
);
    localparam int BYTES  = DATA_W / 8;
    localparam int OFF_W  = $clog2(BYTES);
    localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int SPAN_W = 2 * BYTES;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

    state_t               state;
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     cur_port;
    logic [OFF_W-1:0]     cur_off;
    logic [3:0]           cur_width;
    logic                 cur_we;
    logic                 cur_signed;
    logic                 cur_err;
    logic [DATA_W-1:0]    cur_wdata;
    logic [DATA_W-1:0]    beat0_data;
    logic                 mem_ce_r;
    logic                 mem_we_r;
    logic [ADDR_W-1:0]    mem_addr_r;
    logic [BYTES-1:0]     mem_sel_r;
    logic [DATA_W-1:0]    mem_data_r;
    logic [NUM_PORTS-1:0] resp_valid_r;
    logic                 resp_err_r;

    function automatic logic width_ok(input logic [3:0] w);
        return (w == 4'd1) || (w == 4'd2) || (w == 4'd4) || ((w == 4'd8) && (DATA_W == 64));
    endfunction

    // All-ones over the low w bytes.
    function automatic logic [DATA_W-1:0] byte_mask(input logic [3:0] w);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int b = 0; b < BYTES; b++)
            if (b < int'(w)) m[b*8 +: 8] = 8'hFF;
        return m;
    endfunction

    // Lane enables across two consecutive words: low half is beat 0, high half beat 1.
    function automatic logic [SPAN_W-1:0] lane_span(input logic [OFF_W-1:0] off, input logic [3:0] w);
        logic [SPAN_W-1:0] m;
        m = (SPAN_W'(1) << w) - SPAN_W'(1);
        return m << off;
    endfunction

    // Round-robin pick: scanning downward lets the smallest distance from ptr win.
    logic             grant_any;
    logic [PTR_W-1:0] grant_port;
    always_comb begin : rr_pick
        int idx;
        logic [PTR_W-1:0] pidx;
        grant_any  = 1'b0;
        grant_port = '0;
        idx        = 0;
        pidx       = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx  = (int'(ptr) + i) % NUM_PORTS;
            pidx = PTR_W'(idx);
            if (bus.req_valid[pidx]) begin
                grant_any  = 1'b1;
                grant_port = pidx;
            end
        end
    end

    logic [ADDR_W-1:0] g_addr;
    logic [3:0]        g_width;
    logic [DATA_W-1:0] g_wdata;
    logic              g_we;
    logic              g_signed;
    logic [OFF_W-1:0]  g_off;
    logic [SPAN_W-1:0] g_span;
    logic [DATA_W-1:0] g_data0;

    assign g_addr   = bus.req_addr[int'(grant_port)*ADDR_W +: ADDR_W];
    assign g_width  = bus.req_width[int'(grant_port)*4 +: 4];
    assign g_wdata  = bus.req_wdata[int'(grant_port)*DATA_W +: DATA_W];
    assign g_we     = bus.req_we[grant_port];
    assign g_signed = bus.req_signed[grant_port];
    assign g_off    = g_addr[OFF_W-1:0];
    assign g_span   = lane_span(g_off, g_width);
    assign g_data0  = (g_wdata & byte_mask(g_width)) << (int'(g_off) * 8);

    logic [SPAN_W-1:0] cur_span;
    logic              cur_split;
    logic [DATA_W-1:0] cur_data1;

    assign cur_span  = lane_span(cur_off, cur_width);
    assign cur_split = (int'(cur_off) + int'(cur_width)) > BYTES;
    // Bytes that did not fit in beat 0 start at lane 0 of the next word.
    assign cur_data1 = (cur_wdata & byte_mask(cur_width)) >> ((BYTES - int'(cur_off)) * 8);

    // Load assembly: beat-0 bytes come from the captured word, the rest from the live SRAM output.
    logic [DATA_W-1:0] load_data;
    always_comb begin : load_assemble
        logic [DATA_W-1:0] raw;
        logic              sign;
        if (cur_split)
            raw = (beat0_data >> (int'(cur_off) * 8)) |
                  (bus.mem_data_i << ((BYTES - int'(cur_off)) * 8));
        else
            raw = bus.mem_data_i >> (int'(cur_off) * 8);
        raw  = raw & byte_mask(cur_width);
        sign = 1'b0;
        for (int b = 0; b < BYTES; b++)
            if (b == int'(cur_width) - 1) sign = raw[b*8 + 7];
        load_data = (cur_signed && sign) ? (raw | ~byte_mask(cur_width)) : raw;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            ptr          <= '0;
            cur_port     <= '0;
            cur_off      <= '0;
            cur_width    <= '0;
            cur_we       <= 1'b0;
            cur_signed   <= 1'b0;
            cur_err      <= 1'b0;
            cur_wdata    <= '0;
            beat0_data   <= '0;
            mem_ce_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_sel_r    <= '0;
            mem_data_r   <= '0;
            resp_valid_r <= '0;
            resp_err_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        cur_port   <= grant_port;
                        cur_off    <= g_off;
                        cur_width  <= g_width;
                        cur_we     <= g_we;
                        cur_signed <= g_signed;
                        cur_wdata  <= g_wdata;
                        ptr        <= (grant_port == PTR_W'(NUM_PORTS - 1)) ? '0 : grant_port + 1'b1;
                        if (!width_ok(g_width)) begin
                            cur_err      <= 1'b1;
                            resp_valid_r <= NUM_PORTS'(1) << grant_port;
                            resp_err_r   <= 1'b1;
                            state        <= DONE;
                        end else begin
                            cur_err    <= 1'b0;
                            mem_ce_r   <= 1'b1;
                            mem_we_r   <= g_we;
                            mem_addr_r <= {g_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            mem_sel_r  <= g_span[BYTES-1:0];
                            mem_data_r <= g_we ? g_data0 : '0;
                            state      <= BEAT0;
                        end
                    end
                end
                BEAT0: begin
                    if (cur_split) begin
                        mem_addr_r <= mem_addr_r + ADDR_W'(BYTES);
                        mem_sel_r  <= cur_span[SPAN_W-1:BYTES];
                        mem_data_r <= cur_we ? cur_data1 : '0;
                        state      <= BEAT1;
                    end else begin
                        mem_ce_r     <= 1'b0;
                        mem_we_r     <= 1'b0;
                        mem_sel_r    <= '0;
                        mem_data_r   <= '0;
                        resp_valid_r <= NUM_PORTS'(1) << cur_port;
                        resp_err_r   <= 1'b0;
                        state        <= DONE;
                    end
                end
                BEAT1: begin
                    beat0_data   <= bus.mem_data_i;
                    mem_ce_r     <= 1'b0;
                    mem_we_r     <= 1'b0;
                    mem_sel_r    <= '0;
                    mem_data_r   <= '0;
                    resp_valid_r <= NUM_PORTS'(1) << cur_port;
                    resp_err_r   <= 1'b0;
                    state        <= DONE;
                end
                DONE: begin
                    resp_valid_r <= '0;
                    resp_err_r   <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Grant is combinational so the requester sees ready in the same cycle it is chosen.
    assign bus.req_ready  = (rst && (state == IDLE) && grant_any) ? (NUM_PORTS'(1) << grant_port) : '0;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.resp_data  = ((state == DONE) && !cur_we && !cur_err) ? load_data : '0;
    assign bus.mem_ce     = mem_ce_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_addr_o = mem_addr_r;
    assign bus.mem_sel_o  = mem_sel_r;
    assign bus.mem_data_o = mem_data_r;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
    localparam int NP = 2;
    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW)) bus ();
    mem_access_unit #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_miss = 0;

    // SRAM model: 16 words, read data valid the cycle after mem_ce.
    logic [31:0] mem [0:15];
    logic        poke_en = 1'b0;
    logic [3:0]  poke_idx = '0;
    logic [31:0] poke_val = '0;
    logic [31:0] rdata = '0;
    assign bus.mem_data_i = rdata;

    always @(posedge clk) begin
        if (poke_en) begin
            mem[poke_idx] = poke_val;
        end else if (bus.mem_ce) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_sel_o[b]) mem[bus.mem_addr_o[5:2]][b*8 +: 8] = bus.mem_data_o[b*8 +: 8];
            end else begin
                rdata <= mem[bus.mem_addr_o[5:2]];
            end
        end
    end

    task automatic poke(input int idx, input logic [31:0] val);
        @(negedge clk);
        poke_en = 1'b1; poke_idx = 4'(idx); poke_val = val;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic drive_req(input int p, input logic we, input logic sgn, input logic [31:0] a,
                             input logic [3:0] w, input logic [31:0] d);
        bus.req_valid[p]       = 1'b1;
        bus.req_we[p]          = we;
        bus.req_signed[p]      = sgn;
        bus.req_addr[p*AW +: AW] = a;
        bus.req_width[p*4 +: 4]  = w;
        bus.req_wdata[p*DW +: DW] = d;
    endtask

    task automatic clear_req();
        bus.req_valid = '0; bus.req_we = '0; bus.req_signed = '0;
        bus.req_addr = '0; bus.req_width = '0; bus.req_wdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_req();
        drive_req(0, 1'b0, 1'b0, 32'd4, 4'd4, 32'd0);
        drive_req(1, 1'b1, 1'b0, 32'd8, 4'd4, 32'h1234);
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (bus.req_ready !== 2'b00) begin n_miss++; $display("FAIL rst_ready got %0h exp 0", bus.req_ready); end
        n_vec++; if (bus.mem_ce !== 1'b0) begin n_miss++; $display("FAIL rst_ce got %0h exp 0", bus.mem_ce); end
        n_vec++; if (bus.mem_sel_o !== 4'h0) begin n_miss++; $display("FAIL rst_sel got %0h exp 0", bus.mem_sel_o); end
        n_vec++; if (bus.resp_valid !== 2'b00) begin n_miss++; $display("FAIL rst_rv got %0h exp 0", bus.resp_valid); end
        n_vec++; if (bus.resp_err !== 1'b0) begin n_miss++; $display("FAIL rst_err got %0h exp 0", bus.resp_err); end
        n_vec++; if (bus.resp_data !== 32'h0) begin n_miss++; $display("FAIL rst_data got %0h exp 0", bus.resp_data); end
        clear_req();
        @(negedge clk);
        rst = 1'b1;
        poke(1, 32'h44332211);
        poke(2, 32'h00000000);
    endtask

    task automatic test_aligned_load();
        @(negedge clk);
        drive_req(0, 1'b0, 1'b0, 32'd4, 4'd4, 32'd0);
        #1;
        n_vec++; if (bus.req_ready !== 2'b01) begin n_miss++; $display("FAIL al_ready got %0h exp 1", bus.req_ready); end
        @(negedge clk);
        clear_req();
        n_vec++; if (bus.mem_ce !== 1'b1 || bus.mem_we !== 1'b0) begin n_miss++; $display("FAIL al_ce ce=%0h we=%0h exp 1/0", bus.mem_ce, bus.mem_we); end
        n_vec++; if (bus.mem_addr_o !== 32'd4) begin n_miss++; $display("FAIL al_addr got %0h exp 4", bus.mem_addr_o); end
        n_vec++; if (bus.mem_sel_o !== 4'hF) begin n_miss++; $display("FAIL al_sel got %0h exp f", bus.mem_sel_o); end
        n_vec++; if (bus.mem_data_o !== 32'h0) begin n_miss++; $display("FAIL al_wdata got %0h exp 0", bus.mem_data_o); end
        n_vec++; if (bus.resp_valid !== 2'b00) begin n_miss++; $display("FAIL al_early got %0h exp 0", bus.resp_valid); end
        @(negedge clk);
        n_vec++; if (bus.resp_valid !== 2'b01) begin n_miss++; $display("FAIL al_rv got %0h exp 1", bus.resp_valid); end
        n_vec++; if (bus.resp_err !== 1'b0) begin n_miss++; $display("FAIL al_err got %0h exp 0", bus.resp_err); end
        n_vec++; if (bus.resp_data !== 32'h44332211) begin n_miss++; $display("FAIL al_data got %0h exp 44332211", bus.resp_data); end
        n_vec++; if (bus.mem_ce !== 1'b0) begin n_miss++; $display("FAIL al_ce_off got %0h exp 0", bus.mem_ce); end
        @(negedge clk);
        n_vec++; if (bus.resp_valid !== 2'b00) begin n_miss++; $display("FAIL al_pulse got %0h exp 0", bus.resp_valid); end
    endtask

    task automatic test_signed_byte();
        logic [31:0] exp_d [2];
        exp_d[0] = 32'h000000F4;
        exp_d[1] = 32'hFFFFFFF4;
        poke(1, 32'hF4332211);
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            drive_req(0, 1'b0, 1'(s), 32'd7, 4'd1, 32'd0);
            @(negedge clk);
            clear_req();
            n_vec++; if (bus.mem_sel_o !== 4'h8 || bus.mem_addr_o !== 32'd4) begin n_miss++; $display("FAIL sb_beat%0d sel=%0h addr=%0h exp 8/4", s, bus.mem_sel_o, bus.mem_addr_o); end
            @(negedge clk);
            n_vec++; if (bus.resp_valid !== 2'b01 || bus.resp_data !== exp_d[s]) begin n_miss++; $display("FAIL sb_data%0d rv=%0h data=%0h exp 1/%0h", s, bus.resp_valid, bus.resp_data, exp_d[s]); end
            @(negedge clk);
        end
    endtask

    task automatic test_split();
        logic [31:0] exp_ld [2];
        exp_ld[0] = 32'h0000BEEF;
        exp_ld[1] = 32'hFFFFBEEF;
        @(negedge clk);
        drive_req(1, 1'b1, 1'b0, 32'd7, 4'd2, 32'h0000BEEF);
        #1;
        n_vec++; if (bus.req_ready !== 2'b10) begin n_miss++; $display("FAIL sp_ready got %0h exp 2", bus.req_ready); end
        @(negedge clk);
        clear_req();
        n_vec++; if (bus.mem_ce !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr_o !== 32'd4 || bus.mem_sel_o !== 4'h8)
            begin n_miss++; $display("FAIL sp_b0 ce=%0h we=%0h addr=%0h sel=%0h exp 1/1/4/8", bus.mem_ce, bus.mem_we, bus.mem_addr_o, bus.mem_sel_o); end
        n_vec++; if (bus.mem_data_o !== 32'hEF000000) begin n_miss++; $display("FAIL sp_b0_data got %0h exp ef000000", bus.mem_data_o); end
        @(negedge clk);
        n_vec++; if (bus.mem_ce !== 1'b1 || bus.mem_addr_o !== 32'd8 || bus.mem_sel_o !== 4'h1)
            begin n_miss++; $display("FAIL sp_b1 ce=%0h addr=%0h sel=%0h exp 1/8/1", bus.mem_ce, bus.mem_addr_o, bus.mem_sel_o); end
        n_vec++; if (bus.mem_data_o !== 32'h000000BE) begin n_miss++; $display("FAIL sp_b1_data got %0h exp be", bus.mem_data_o); end
        n_vec++; if (bus.resp_valid !== 2'b00) begin n_miss++; $display("FAIL sp_early got %0h exp 0", bus.resp_valid); end
        @(negedge clk);
        n_vec++; if (bus.resp_valid !== 2'b10 || bus.resp_err !== 1'b0 || bus.resp_data !== 32'h0)
            begin n_miss++; $display("FAIL sp_resp rv=%0h err=%0h data=%0h exp 2/0/0", bus.resp_valid, bus.resp_err, bus.resp_data); end
        n_vec++; if (mem[1] !== 32'hEF332211 || mem[2] !== 32'h000000BE)
            begin n_miss++; $display("FAIL sp_mem w1=%0h w2=%0h exp ef332211/be", mem[1], mem[2]); end
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            drive_req(0, 1'b0, 1'(s), 32'd7, 4'd2, 32'd0);
            @(negedge clk);
            clear_req();
            @(negedge clk);
            n_vec++; if (bus.mem_sel_o !== 4'h1 || bus.resp_valid !== 2'b00) begin n_miss++; $display("FAIL spl_b1%0d sel=%0h rv=%0h exp 1/0", s, bus.mem_sel_o, bus.resp_valid); end
            @(negedge clk);
            n_vec++; if (bus.resp_valid !== 2'b01 || bus.resp_data !== exp_ld[s]) begin n_miss++; $display("FAIL spl_data%0d rv=%0h data=%0h exp 1/%0h", s, bus.resp_valid, bus.resp_data, exp_ld[s]); end
        end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        logic [3:0] bad [2];
        bad[0] = 4'd3;
        bad[1] = 4'd8;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive_req(0, 1'b0, 1'b0, 32'd4, bad[k], 32'hFFFF);
            @(negedge clk);
            clear_req();
            n_vec++; if (bus.mem_ce !== 1'b0) begin n_miss++; $display("FAIL il_ce%0d got %0h exp 0", k, bus.mem_ce); end
            n_vec++; if (bus.resp_valid !== 2'b01 || bus.resp_err !== 1'b1 || bus.resp_data !== 32'h0)
                begin n_miss++; $display("FAIL il_resp%0d rv=%0h err=%0h data=%0h exp 1/1/0", k, bus.resp_valid, bus.resp_err, bus.resp_data); end
            @(negedge clk);
            n_vec++; if (bus.resp_valid !== 2'b00 || bus.resp_err !== 1'b0) begin n_miss++; $display("FAIL il_pulse%0d rv=%0h err=%0h exp 0/0", k, bus.resp_valid, bus.resp_err); end
        end
    endtask

    task automatic test_arbitration();
        logic [1:0] gr [4];
        int gc [4];
        int g;
        logic prev;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        drive_req(0, 1'b0, 1'b0, 32'd4, 4'd4, 32'd0);
        drive_req(1, 1'b0, 1'b0, 32'd4, 4'd4, 32'd0);
        g = 0;
        prev = 1'b0;
        for (int c = 0; c < 40 && g < 4; c++) begin
            #1;
            if (bus.req_ready !== 2'b00) begin
                n_vec++; if (prev) begin n_miss++; $display("FAIL arb_b2b cycle %0d ready=%0h exp 0", c, bus.req_ready); end
                gr[g] = bus.req_ready;
                gc[g] = c;
                g++;
                prev = 1'b1;
            end else begin
                prev = 1'b0;
            end
            @(negedge clk);
        end
        n_vec++; if (g != 4) begin n_miss++; $display("FAIL arb_timeout grants=%0d exp 4", g); end
        for (int k = 0; k < g; k++) begin
            n_vec++; if (gr[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin n_miss++; $display("FAIL arb_order%0d got %0h exp %0h", k, gr[k], (k % 2 == 0) ? 2'b01 : 2'b10); end
            if (k > 0) begin
                n_vec++; if (gc[k] - gc[k-1] != 3) begin n_miss++; $display("FAIL arb_gap%0d got %0d exp 3", k, gc[k] - gc[k-1]); end
            end
        end
        clear_req();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_beat1();
        @(negedge clk);
        drive_req(0, 1'b0, 1'b0, 32'd7, 4'd2, 32'd0);
        @(negedge clk);
        clear_req();
        @(negedge clk);
        n_vec++; if (bus.mem_ce !== 1'b1 || bus.mem_sel_o !== 4'h1) begin n_miss++; $display("FAIL rb_beat1 ce=%0h sel=%0h exp 1/1", bus.mem_ce, bus.mem_sel_o); end
        rst = 1'b0;
        #1;
        n_vec++; if (bus.mem_ce !== 1'b0 || bus.mem_sel_o !== 4'h0) begin n_miss++; $display("FAIL rb_drop ce=%0h sel=%0h exp 0/0", bus.mem_ce, bus.mem_sel_o); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_vec++; if (bus.resp_valid !== 2'b00) begin n_miss++; $display("FAIL rb_norv%0d got %0h exp 0", k, bus.resp_valid); end
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.resp_valid !== 2'b00) begin n_miss++; $display("FAIL rb_norv_rel got %0h exp 0", bus.resp_valid); end
        drive_req(1, 1'b0, 1'b0, 32'd4, 4'd4, 32'd0);
        #1;
        n_vec++; if (bus.req_ready !== 2'b10) begin n_miss++; $display("FAIL rb_ready got %0h exp 2", bus.req_ready); end
        @(negedge clk);
        clear_req();
        @(negedge clk);
        n_vec++; if (bus.resp_valid !== 2'b10 || bus.resp_data !== 32'hEF332211)
            begin n_miss++; $display("FAIL rb_next rv=%0h data=%0h exp 2/ef332211", bus.resp_valid, bus.resp_data); end
        @(negedge clk);
    endtask

    initial begin
        clear_req();
        test_reset();
        test_aligned_load();
        test_signed_byte();
        test_split();
        test_illegal();
        test_arbitration();
        test_reset_beat1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
